stage4_ex_mem_buffer: RTL and testbench

- Parametrised elastic EX→MEM pipeline buffer for the stage4 pipeline. It replaces the single fixed ex_mem_reg latch with a DEPTH-entry circular queue and a valid/ready handshake on both sides.
- It carries the opaque EX payload plus writeback fields (reg_write, rd, wdata).
- It exposes a youngest-first register-forwarding lookup across all buffered entries, so execute can bypass from any in-flight MEM-bound instruction.

---
 rtl/stage4_types_pkg.sv | 35 +++
 rtl/stage4_ex_mem_buffer_if.sv | 28 ++
 rtl/stage4_ex_mem_buffer_fwd_match.sv | 50 +++++
 rtl/stage4_ex_mem_buffer.sv | 145 ++++++++++++++
 tb/tb_stage4_ex_mem_buffer.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage4_types_pkg.sv
// Shared types and helpers for the stage4 EX->MEM elastic buffer.
// Latency: n/a (types, constants and constant-foldable functions only).
// Backpressure: n/a.
//
// Contents:
//   STAGE4_BUF_MAX_DEPTH   - largest supported buffer depth
//   ex_mem_buf_entry_t     - one buffered entry at the default widths
//   stage4_buf_ptr_w()     - pointer width for a given depth (never zero)
//   stage4_buf_next_ptr()  - pointer increment with explicit wrap at depth-1
package stage4_types_pkg;

    localparam int STAGE4_BUF_MAX_DEPTH = 8;

    localparam int STAGE4_PAYLOAD_W = 64;
    localparam int STAGE4_DATA_W    = 32;
    localparam int STAGE4_RSEL_W    = 5;

    typedef struct packed {
        logic [STAGE4_PAYLOAD_W-1:0] payload;
        logic                        reg_write;
        logic [STAGE4_RSEL_W-1:0]    rd;
        logic [STAGE4_DATA_W-1:0]    wdata;
    } ex_mem_buf_entry_t;

    // A depth of 1 still needs a 1-bit pointer so the storage index is legal.
    function automatic int stage4_buf_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wraps explicitly so non-power-of-two depths work.
    function automatic int stage4_buf_next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/stage4_ex_mem_buffer_if.sv
// Valid/ready channel carrying one EX->MEM entry (payload + writeback fields).
// Latency: none (wires only).
// Backpressure: the slave drives ready; a beat transfers when valid && ready.
//
// Signals: valid, ready, payload[PAYLOAD_W], reg_write, rd[RSEL_W], wdata[DATA_W]
// Modports: master (produces the entry), slave (consumes the entry).
interface stage4_ex_mem_buffer_if #(
    parameter int PAYLOAD_W = 64,
    parameter int DATA_W    = 32,
    parameter int RSEL_W    = 5
) ();
    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] payload;
    logic                 reg_write;
    logic [RSEL_W-1:0]    rd;
    logic [DATA_W-1:0]    wdata;

    modport master (
        output valid, payload, reg_write, rd, wdata,
        input  ready
    );

    modport slave (
        input  valid, payload, reg_write, rd, wdata,
        output ready
    );
endinterface

// File: rtl/stage4_ex_mem_buffer_fwd_match.sv
// Youngest-first register-forwarding search over the live buffer entries.
// Latency: purely combinational on the current buffer state.
// Backpressure: none; a lookup is answered every cycle.
//
// Ports: i_reg_write/i_rd/i_wdata - entry storage arrays; i_rd_ptr - head index;
//        i_count - live entries; i_addr - register looked up;
//        o_hit/o_data - youngest matching entry's wdata (0 when no hit).
module stage4_fwd_match #(
    parameter int DATA_W = 32,
    parameter int RSEL_W = 5,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 1,
    parameter int CNT_W  = 2
) (
    input  logic              i_reg_write [DEPTH],
    input  logic [RSEL_W-1:0] i_rd        [DEPTH],
    input  logic [DATA_W-1:0] i_wdata     [DEPTH],
    input  logic [PTR_W-1:0]  i_rd_ptr,
    input  logic [CNT_W-1:0]  i_count,
    input  logic [RSEL_W-1:0] i_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    // w_idx[g] is the storage slot holding the g-th oldest entry.
    logic [PTR_W-1:0] w_idx  [DEPTH];
    logic             w_live [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        logic [PTR_W:0] w_sum;
        assign w_sum     = {1'b0, i_rd_ptr} + (PTR_W+1)'(g);
        assign w_idx[g]  = (w_sum >= (PTR_W+1)'(DEPTH)) ? PTR_W'(w_sum - (PTR_W+1)'(DEPTH))
                                                        : PTR_W'(w_sum);
        assign w_live[g] = (CNT_W'(g) < i_count);
    end

    // Scan oldest to youngest; a later match overwrites, so the youngest wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live[i] && i_reg_write[w_idx[i]] &&
                (i_rd[w_idx[i]] == i_addr) && (i_addr != '0)) begin
                o_hit  = 1'b1;
                o_data = i_wdata[w_idx[i]];
            end
        end
    end

endmodule

// File: rtl/stage4_ex_mem_buffer.sv
// Elastic DEPTH-entry EX->MEM buffer with youngest-first register forwarding.
// Latency: 1 cycle EX->MEM minimum (registered, no pass-through).
// Backpressure: ex.ready = not full (independent of mem.ready); flush kills all entries.
//
// Ports: CLK, nRST (async active-low), flush (sync kill),
//        ex  (slave channel from EX), mem (master channel to MEM),
//        fwd_rs1/fwd_rs2 lookup addresses -> fwd_rs*_hit / fwd_rs*_data,
//        count (current occupancy).
// Build option: define STAGE4_BUF_FWD_EN to instantiate the forwarding match
// logic; otherwise the forwarding outputs are tied to zero.
module stage4_ex_mem_buffer
    import stage4_types_pkg::*;
#(
    parameter int PAYLOAD_W = 64,
    parameter int DATA_W    = 32,
    parameter int RSEL_W    = 5,
    parameter int DEPTH     = 2
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       flush,
    stage4_ex_mem_buffer_if.slave      ex,
    stage4_ex_mem_buffer_if.master     mem,
    input  logic [RSEL_W-1:0]          fwd_rs1,
    input  logic [RSEL_W-1:0]          fwd_rs2,
    output logic                       fwd_rs1_hit,
    output logic                       fwd_rs2_hit,
    output logic [DATA_W-1:0]          fwd_rs1_data,
    output logic [DATA_W-1:0]          fwd_rs2_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = stage4_buf_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    if (DEPTH < 1 || DEPTH > STAGE4_BUF_MAX_DEPTH) begin : g_bad_depth
        $error("stage4_ex_mem_buffer: DEPTH out of range 1..8");
    end

    logic [PAYLOAD_W-1:0] r_payload   [DEPTH];
    logic                 r_reg_write [DEPTH];
    logic [RSEL_W-1:0]    r_rd        [DEPTH];
    logic [DATA_W-1:0]    r_wdata     [DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [CNT_W-1:0]     r_count;

    logic w_nonempty;
    logic w_push;
    logic w_pop;

    assign w_nonempty = (r_count != '0);
    assign ex.ready   = (r_count != CNT_W'(DEPTH));
    // Hiding the head during flush means no pop can be reported on a killed entry.
    assign mem.valid  = w_nonempty && !flush;
    assign w_push     = ex.valid && ex.ready && !flush;
    assign w_pop      = mem.valid && mem.ready;

    assign mem.payload   = w_nonempty ? r_payload[r_rd_ptr]   : '0;
    assign mem.reg_write = w_nonempty ? r_reg_write[r_rd_ptr] : 1'b0;
    assign mem.rd        = w_nonempty ? r_rd[r_rd_ptr]        : '0;
    assign mem.wdata     = w_nonempty ? r_wdata[r_rd_ptr]     : '0;
    assign count         = r_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_reg_write[i] <= 1'b0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_reg_write[r_wr_ptr] <= ex.reg_write;
                r_wr_ptr <= PTR_W'(stage4_buf_next_ptr(int'(r_wr_ptr), DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= PTR_W'(stage4_buf_next_ptr(int'(r_rd_ptr), DEPTH));
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Data fields need no reset: they are only observed while the entry is live.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_payload[r_wr_ptr] <= ex.payload;
            r_rd[r_wr_ptr]      <= ex.rd;
            r_wdata[r_wr_ptr]   <= ex.wdata;
        end
    end

`ifdef STAGE4_BUF_FWD_EN
    stage4_fwd_match #(
        .DATA_W (DATA_W),
        .RSEL_W (RSEL_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_fwd_rs1 (
        .i_reg_write (r_reg_write),
        .i_rd        (r_rd),
        .i_wdata     (r_wdata),
        .i_rd_ptr    (r_rd_ptr),
        .i_count     (r_count),
        .i_addr      (fwd_rs1),
        .o_hit       (fwd_rs1_hit),
        .o_data      (fwd_rs1_data)
    );

    stage4_fwd_match #(
        .DATA_W (DATA_W),
        .RSEL_W (RSEL_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_fwd_rs2 (
        .i_reg_write (r_reg_write),
        .i_rd        (r_rd),
        .i_wdata     (r_wdata),
        .i_rd_ptr    (r_rd_ptr),
        .i_count     (r_count),
        .i_addr      (fwd_rs2),
        .o_hit       (fwd_rs2_hit),
        .o_data      (fwd_rs2_data)
    );
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwd_rs1, fwd_rs2};
    assign fwd_rs1_hit  = 1'b0;
    assign fwd_rs2_hit  = 1'b0;
    assign fwd_rs1_data = '0;
    assign fwd_rs2_data = '0;
`endif

endmodule

// File: tb/tb_stage4_ex_mem_buffer.sv
// Bench for stage4_ex_mem_buffer: a DEPTH=2 and a DEPTH=3 instance share one
// directed stimulus stream; each is compared every cycle against a queue model.
// Model: an entry list where a push appends, a pop removes the front, flush empties.
module tb_stage4_ex_mem_buffer;
    import stage4_types_pkg::*;

    logic        CLK;
    logic        nRST;
    logic        flush;
    logic        ex_valid;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_wdata;
    logic [63:0] ex_payload;
    logic        mem_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    int total;
    int bad;

    logic        o_mv  [2];
    logic        o_er  [2];
    logic        o_rw  [2];
    logic [4:0]  o_rd  [2];
    logic [31:0] o_wd  [2];
    logic [63:0] o_pl  [2];
    logic [1:0]  o_cnt [2];
    logic        h1    [2];
    logic        h2    [2];
    logic [31:0] d1    [2];
    logic [31:0] d2    [2];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    stage4_ex_mem_buffer_if #(.PAYLOAD_W(64), .DATA_W(32), .RSEL_W(5)) ex_a ();
    stage4_ex_mem_buffer_if #(.PAYLOAD_W(64), .DATA_W(32), .RSEL_W(5)) mem_a ();
    stage4_ex_mem_buffer_if #(.PAYLOAD_W(64), .DATA_W(32), .RSEL_W(5)) ex_b ();
    stage4_ex_mem_buffer_if #(.PAYLOAD_W(64), .DATA_W(32), .RSEL_W(5)) mem_b ();

    assign ex_a.valid     = ex_valid;
    assign ex_a.payload   = ex_payload;
    assign ex_a.reg_write = ex_reg_write;
    assign ex_a.rd        = ex_rd;
    assign ex_a.wdata     = ex_wdata;
    assign mem_a.ready    = mem_ready;
    assign ex_b.valid     = ex_valid;
    assign ex_b.payload   = ex_payload;
    assign ex_b.reg_write = ex_reg_write;
    assign ex_b.rd        = ex_rd;
    assign ex_b.wdata     = ex_wdata;
    assign mem_b.ready    = mem_ready;

    assign o_mv[0] = mem_a.valid;     assign o_mv[1] = mem_b.valid;
    assign o_er[0] = ex_a.ready;      assign o_er[1] = ex_b.ready;
    assign o_rw[0] = mem_a.reg_write; assign o_rw[1] = mem_b.reg_write;
    assign o_rd[0] = mem_a.rd;        assign o_rd[1] = mem_b.rd;
    assign o_wd[0] = mem_a.wdata;     assign o_wd[1] = mem_b.wdata;
    assign o_pl[0] = mem_a.payload;   assign o_pl[1] = mem_b.payload;

    stage4_ex_mem_buffer #(.PAYLOAD_W(64), .DATA_W(32), .RSEL_W(5), .DEPTH(2)) dut_a (
        .CLK(CLK), .nRST(nRST), .flush(flush), .ex(ex_a), .mem(mem_a),
        .fwd_rs1(rs1), .fwd_rs2(rs2),
        .fwd_rs1_hit(h1[0]), .fwd_rs2_hit(h2[0]),
        .fwd_rs1_data(d1[0]), .fwd_rs2_data(d2[0]), .count(o_cnt[0])
    );

    stage4_ex_mem_buffer #(.PAYLOAD_W(64), .DATA_W(32), .RSEL_W(5), .DEPTH(3)) dut_b (
        .CLK(CLK), .nRST(nRST), .flush(flush), .ex(ex_b), .mem(mem_b),
        .fwd_rs1(rs1), .fwd_rs2(rs2),
        .fwd_rs1_hit(h1[1]), .fwd_rs2_hit(h2[1]),
        .fwd_rs1_data(d1[1]), .fwd_rs2_data(d2[1]), .count(o_cnt[1])
    );

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    ex_mem_buf_entry_t qa[$];
    ex_mem_buf_entry_t qb[$];

    always @(posedge CLK or negedge nRST) begin : model
        ex_mem_buf_entry_t q[$];
        ex_mem_buf_entry_t e;
        int  dep;
        bit  do_push;
        bit  do_pop;
        if (!nRST) begin
            qa.delete();
            qb.delete();
        end else begin
            e.payload   = ex_payload;
            e.reg_write = ex_reg_write;
            e.rd        = ex_rd;
            e.wdata     = ex_wdata;
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin q = qa; dep = 2; end
                else        begin q = qb; dep = 3; end
                if (flush) begin
                    q.delete();
                end else begin
                    do_pop  = (q.size() != 0) && mem_ready;
                    do_push = ex_valid && (q.size() != dep);
                    if (do_pop)  void'(q.pop_front());
                    if (do_push) q.push_back(e);
                end
                if (d == 0) qa = q; else qb = q;
            end
        end
    end

    always @(negedge CLK) begin : compare
        ex_mem_buf_entry_t q[$];
        ex_mem_buf_entry_t h;
        int          dep;
        logic        eh1, eh2;
        logic [31:0] ed1, ed2;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin q = qa; dep = 2; end
            else        begin q = qb; dep = 3; end
            h = (q.size() != 0) ? q[0] : '0;
            eh1 = 1'b0; ed1 = '0; eh2 = 1'b0; ed2 = '0;
`ifdef STAGE4_BUF_FWD_EN
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (!eh1 && q[k].reg_write && q[k].rd == rs1 && rs1 != 0) begin
                    eh1 = 1'b1; ed1 = q[k].wdata;
                end
                if (!eh2 && q[k].reg_write && q[k].rd == rs2 && rs2 != 0) begin
                    eh2 = 1'b1; ed2 = q[k].wdata;
                end
            end
`endif
            chk("mem_valid",     d, 64'(o_mv[d]),  64'((q.size() != 0) && !flush));
            chk("ex_ready",      d, 64'(o_er[d]),  64'(q.size() != dep));
            chk("count",         d, 64'(o_cnt[d]), 64'(q.size()));
            chk("mem_payload",   d, o_pl[d],       h.payload);
            chk("mem_reg_write", d, 64'(o_rw[d]),  64'(h.reg_write));
            chk("mem_rd",        d, 64'(o_rd[d]),  64'(h.rd));
            chk("mem_wdata",     d, 64'(o_wd[d]),  64'(h.wdata));
            chk("fwd_rs1_hit",   d, 64'(h1[d]),    64'(eh1));
            chk("fwd_rs1_data",  d, 64'(d1[d]),    64'(ed1));
            chk("fwd_rs2_hit",   d, 64'(h2[d]),    64'(eh2));
            chk("fwd_rs2_data",  d, 64'(d2[d]),    64'(ed2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] wd, input logic rw);
        ex_valid     = 1'b1;
        ex_rd        = rd;
        ex_wdata     = wd;
        ex_reg_write = rw;
        ex_payload   = {wd, 24'hA5A5A5, 3'b000, rd};
    endtask

    initial begin
        total = 0; bad = 0;
        nRST = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_reg_write = 1'b0;
        ex_rd = '0; ex_wdata = '0; ex_payload = '0; mem_ready = 1'b0;
        rs1 = '0; rs2 = '0;

        // Reset values
        repeat (2) step();
        chk("rst_mem_valid", 0, 64'(o_mv[0]),  64'd0);
        chk("rst_ex_ready",  0, 64'(o_er[0]),  64'd1);
        chk("rst_count",     0, 64'(o_cnt[0]), 64'd0);
        chk("rst_mem_rd",    0, 64'(o_rd[0]),  64'd0);
        nRST = 1'b1;
        step();

        // Single push, visible one cycle later, forwardable
        push(5'd5, 32'hDEADBEEF, 1'b1);
        rs1 = 5'd5;
        step();
        chk("p1_mem_valid", 0, 64'(o_mv[0]),  64'd1);
        chk("p1_mem_rd",    0, 64'(o_rd[0]),  64'd5);
        chk("p1_count",     0, 64'(o_cnt[0]), 64'd1);
`ifdef STAGE4_BUF_FWD_EN
        chk("p1_fwd_hit",   0, 64'(h1[0]),    64'd1);
        chk("p1_fwd_data",  0, 64'(d1[0]),    64'hDEADBEEF);
`endif
        ex_valid = 1'b0;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;

        // Fill DEPTH=2, hold a third push, then drain
        push(5'd3, 32'h33, 1'b1);
        step();
        push(5'd4, 32'h44, 1'b1);
        step();
        chk("full_count",    0, 64'(o_cnt[0]), 64'd2);
        chk("full_ex_ready", 0, 64'(o_er[0]),  64'd0);
        push(5'd6, 32'h66, 1'b1);
        repeat (3) step();
        chk("hold_count",  0, 64'(o_cnt[0]), 64'd2);
        chk("hold_mem_rd", 0, 64'(o_rd[0]),  64'd3);
        chk("hold_b_count", 1, 64'(o_cnt[1]), 64'd3);
        ex_valid = 1'b0;
        mem_ready = 1'b1;
        step();
        chk("pop_count",    0, 64'(o_cnt[0]), 64'd1);
        chk("pop_ex_ready", 0, 64'(o_er[0]),  64'd1);
        chk("pop_mem_rd",   0, 64'(o_rd[0]),  64'd4);
        repeat (2) step();
        mem_ready = 1'b0;

        // Youngest match wins
        rs2 = 5'd7;
        push(5'd7, 32'h11, 1'b1);
        step();
        push(5'd7, 32'h22, 1'b1);
        step();
        ex_valid = 1'b0;
`ifdef STAGE4_BUF_FWD_EN
        chk("young_data", 0, 64'(d2[0]), 64'h22);
`endif
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
`ifdef STAGE4_BUF_FWD_EN
        chk("young_pop1_data", 0, 64'(d2[0]), 64'h22);
`endif
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("young_empty_hit", 0, 64'(h2[0]), 64'd0);

        // rd=0 and reg_write=0 never match
        rs1 = 5'd0;
        push(5'd0, 32'h55, 1'b1);
        step();
        rs2 = 5'd9;
        push(5'd9, 32'h99, 1'b0);
        step();
        ex_valid = 1'b0;
        #1;
        chk("rd0_hit",  0, 64'(h1[0]), 64'd0);
        chk("rw0_hit",  0, 64'(h2[0]), 64'd0);
        mem_ready = 1'b1;
        repeat (3) step();
        mem_ready = 1'b0;

        // Interleaved push/pop so both pointer sets wrap
        for (int i = 0; i < 10; i++) begin
            rs1 = 5'(i);
            push(5'(i + 1), 32'h100 + 32'(i), 1'b1);
            mem_ready = ((i % 3) != 0);
            step();
        end
        ex_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (4) step();
        mem_ready = 1'b0;
        chk("wrap_drained", 1, 64'(o_cnt[1]), 64'd0);

        // Flush a full buffer while a push is offered
        push(5'd10, 32'hA0, 1'b1);
        step();
        push(5'd11, 32'hA1, 1'b1);
        step();
        push(5'd12, 32'hA2, 1'b1);
        step();
        flush = 1'b1;
        push(5'd13, 32'hA3, 1'b1);
        #1;
        chk("flush_mem_valid", 0, 64'(o_mv[0]), 64'd0);
        chk("flush_mem_valid", 1, 64'(o_mv[1]), 64'd0);
        step();
        flush = 1'b0;
        ex_valid = 1'b0;
        #1;
        chk("post_flush_count", 0, 64'(o_cnt[0]), 64'd0);
        chk("post_flush_count", 1, 64'(o_cnt[1]), 64'd0);
        chk("post_flush_valid", 0, 64'(o_mv[0]),  64'd0);

        // Asynchronous reset mid-stream
        push(5'd14, 32'hB0, 1'b1);
        step();
        push(5'd15, 32'hB1, 1'b1);
        step();
        ex_valid = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_mem_valid", 0, 64'(o_mv[0]),  64'd0);
        chk("arst_mem_rd",    0, 64'(o_rd[0]),  64'd0);
        chk("arst_count",     0, 64'(o_cnt[0]), 64'd0);
        chk("arst_ex_ready",  0, 64'(o_er[0]),  64'd1);
        chk("arst_count",     1, 64'(o_cnt[1]), 64'd0);
        step();
        nRST = 1'b1;
        push(5'd16, 32'hC0, 1'b1);
        step();
        ex_valid = 1'b0;
        chk("after_arst_rd", 0, 64'(o_rd[0]), 64'd16);
        mem_ready = 1'b1;
        repeat (2) step();
        mem_ready = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
